// File: rtl/vga_pkg.sv
// vga_pkg: 640x480@60 timing constants and the coordinate type
// shared by the VGA timing generator.
package vga_pkg;

  typedef logic [9:0] coord_t;

  localparam coord_t H_VIS   = 10'd640;
  localparam coord_t H_FP    = 10'd16;
  localparam coord_t H_SYNC  = 10'd96;
  localparam coord_t H_BP    = 10'd48;
  localparam coord_t H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;

  localparam coord_t V_VIS   = 10'd480;
  localparam coord_t V_FP    = 10'd10;
  localparam coord_t V_SYNC  = 10'd2;
  localparam coord_t V_BP    = 10'd33;
  localparam coord_t V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  localparam coord_t H_LAST = H_TOTAL - 10'd1;
  localparam coord_t V_LAST = V_TOTAL - 10'd1;

  localparam coord_t H_SYNC_FIRST = H_VIS + H_FP;
  localparam coord_t H_SYNC_LAST  = H_VIS + H_FP + H_SYNC - 10'd1;
  localparam coord_t V_SYNC_FIRST = V_VIS + V_FP;
  localparam coord_t V_SYNC_LAST  = V_VIS + V_FP + V_SYNC - 10'd1;

endpackage

// File: rtl/tick_divider.sv
// tick_divider: one-clk pixel enable every CLK_DIV system clocks,
// held low during reset and on the first edge after it.
module tick_divider #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

  logic [W-1:0] r_cnt;
  logic         r_run;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_run <= 1'b0;
    end else begin
      r_run <= 1'b1;
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
    end
  end

  // r_run keeps reset off the combinational path to tick
  assign tick = r_run && (r_cnt == LAST);

endmodule

// File: rtl/vga_timing.sv
// vga_timing: 800x525 raster counters, sync pulses and line/frame
// strobes for 640x480 video, advanced on each pixel tick.
import vga_pkg::*;

module vga_timing #(
  parameter int CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       reset,
  output logic       pix_tick,
  output logic [9:0] col,
  output logic [9:0] row,
  output logic       visible,
  output logic       hsync_n,
  output logic       vsync_n,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_cnt
);

  coord_t     r_col;
  coord_t     r_row;
  logic [7:0] r_frame_cnt;
  logic       w_tick;
  logic       w_col_wrap;
  logic       w_row_wrap;
  logic       w_line;

  tick_divider #(.CLK_DIV(CLK_DIV)) u_div (
    .clk   (clk),
    .reset (reset),
    .tick  (w_tick)
  );

  assign w_col_wrap = (r_col == H_LAST);
  assign w_row_wrap = (r_row == V_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_col       <= '0;
      r_row       <= '0;
      r_frame_cnt <= '0;
    end else if (w_tick) begin
      r_col <= w_col_wrap ? '0 : r_col + 10'd1;
      if (w_col_wrap) begin
        r_row <= w_row_wrap ? '0 : r_row + 10'd1;
        if (w_row_wrap)
          r_frame_cnt <= r_frame_cnt + 8'd1;
      end
    end
  end

  assign w_line = w_tick && (r_col == '0);

  assign pix_tick    = w_tick;
  assign col         = r_col;
  assign row         = r_row;
  assign frame_cnt   = r_frame_cnt;
  assign visible     = (r_col < H_VIS) && (r_row < V_VIS);
  assign hsync_n     = !((r_col >= H_SYNC_FIRST) &&
                         (r_col <= H_SYNC_LAST));
  assign vsync_n     = !((r_row >= V_SYNC_FIRST) &&
                         (r_row <= V_SYNC_LAST));
  assign line_start  = w_line;
  assign frame_start = w_line && (r_row == '0);

endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: CLK_DIV 1/2/4 instances against an absolute-time
// pixel model; expectations queued at posedge, compared at negedge.
`timescale 1ns/1ps
module tb_vga_timing;

  typedef struct packed {
    logic       tick;
    logic [9:0] col;
    logic [9:0] row;
    logic       vis;
    logic       hs;
    logic       vs;
    logic       ls;
    logic       fs;
    logic [7:0] fc;
  } obs_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  longint cyc = 0;

  logic       frc_go = 1'b0;
  logic [9:0] frc_col = '0;
  logic [9:0] frc_row = '0;
  logic [7:0] frc_fc = '0;

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // pixels advanced after k non-reset edges
  function automatic longint adv(int d, longint k);
    if (d == 1) return (k > 0) ? k - 1 : 0;
    return k / d;
  endfunction

  function automatic obs_t model(int d, longint k, longint b);
    obs_t o;
    longint p;
    p = b + adv(d, k);
    o.tick = (k >= 1) && ((k % d) == d - 1);
    o.col = 10'(p % 800);
    o.row = 10'((p / 800) % 525);
    o.fc = 8'((p / 420000) % 256);
    o.vis = (o.col < 640) && (o.row < 480);
    o.hs = !(o.col >= 656 && o.col <= 751);
    o.vs = !(o.row >= 490 && o.row <= 491);
    o.ls = o.tick && (o.col == 0);
    o.fs = o.ls && (o.row == 0);
    return o;
  endfunction

  task automatic chk(string nm, int d, longint got, longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s D=%0d got %0d exp %0d",
               nm, d, got, exp);
    end
  endtask

  for (genvar gi = 0; gi < 3; gi++) begin : g
    localparam int D = (gi == 0) ? 1 : (gi == 1) ? 2 : 4;

    logic       tick, vis, hs, vs, ls, fs;
    logic [9:0] col, row;
    logic [7:0] fc;
    obs_t       act;
    obs_t       q[$];
    longint     n = 0;
    longint     base = 0;
    longint     last_ls = 0;
    bit         l_ok = 0, h_ok = 0, v_ok = 0;
    int         hcnt = 0, vcnt = 0;

    vga_timing #(.CLK_DIV(D)) dut (
      .clk         (clk),
      .reset       (reset),
      .pix_tick    (tick),
      .col         (col),
      .row         (row),
      .visible     (vis),
      .hsync_n     (hs),
      .vsync_n     (vs),
      .line_start  (ls),
      .frame_start (fs),
      .frame_cnt   (fc)
    );

    assign act = {tick, col, row, vis, hs, vs, ls, fs, fc};

    initial forever begin
      @(posedge clk);
      if (reset) begin
        n = 0;
        base = 0;
      end else begin
        n = n + 1;
      end
      q.push_back(model(D, n, base));
    end

    initial forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        obs_t e;
        e = q.pop_front();
        checks++;
        if (act !== e) begin
          errors++;
          $display("FAIL model D=%0d cyc=%0d got t%b c%0d r%0d f%0d %b exp t%b c%0d r%0d f%0d %b",
                   D, cyc, act.tick, act.col, act.row, act.fc,
                   {act.vis, act.hs, act.vs, act.ls, act.fs},
                   e.tick, e.col, e.row, e.fc,
                   {e.vis, e.hs, e.vs, e.ls, e.fs});
        end
      end
      if (ls) begin
        if (l_ok) chk("line_period", D, cyc - last_ls, 800 * D);
        l_ok = 1;
        last_ls = cyc;
      end
      if (!hs) hcnt++;
      else begin
        if (hcnt > 0 && h_ok) chk("hsync_width", D, hcnt, 96 * D);
        hcnt = 0;
        h_ok = 1;
      end
      if (!vs) vcnt++;
      else begin
        if (vcnt > 0 && v_ok) chk("vsync_width", D, vcnt, 1600 * D);
        vcnt = 0;
        v_ok = 1;
      end
      if (reset || frc_go) begin
        l_ok = 0;
        h_ok = 0;
        v_ok = 0;
      end
      if (frc_go) begin
        force dut.r_col = frc_col;
        force dut.r_row = frc_row;
        force dut.r_frame_cnt = frc_fc;
        release dut.r_col;
        release dut.r_row;
        release dut.r_frame_cnt;
        base = longint'(frc_fc) * 420000 + longint'(frc_row) * 800
             + longint'(frc_col) - adv(D, n);
      end
    end
  end

  task automatic step(int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic jump(int r, int c, int f);
    frc_row = 10'(r);
    frc_col = 10'(c);
    frc_fc = 8'(f);
    frc_go = 1'b1;
    step(1);
    frc_go = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    step(4);
    reset = 1'b0;
    step(7000 + int'($urandom_range(0, 500)));
    jump(489, 790, 0);
    step(10000);
    jump(524, 780, 0);
    step(100);
    jump(524, 795, 255);
    step(200);
    jump(300, 700, 0);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(7000);
    jump(int'($urandom_range(0, 524)), int'($urandom_range(0, 799)),
         int'($urandom_range(0, 255)));
    step(int'($urandom_range(100, 3000)));
    reset = 1'b1;
    step(int'($urandom_range(1, 3)));
    reset = 1'b0;
    step(int'($urandom_range(100, 2000)));
    step(2);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing.md
VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2, meaning system clocks per pixel; legal values 1..4.
REQ-002 SHALL have port clk, input, 1 bit: system clock (50 MHz); sole clock.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port pix_tick, output, 1 bit: pixel enable, high one clk in every CLK_DIV.
REQ-005 SHALL have port col, output, 10 bits: horizontal counter, 0..799.
REQ-006 SHALL have port row, output, 10 bits: vertical counter, 0..524.
REQ-007 SHALL have port visible, output, 1 bit: high when col<640 and row<480.
REQ-008 SHALL have ports hsync_n and vsync_n, outputs, 1 bit each: active-low sync pulses.
REQ-009 SHALL have port line_start, output, 1 bit: one-clk strobe at the start of each line.
REQ-010 SHALL have port frame_start, output, 1 bit: one-clk strobe at the start of each frame.
REQ-011 SHALL have port frame_cnt, output, 8 bits: count of completed frames.

Function
REQ-012 SHALL run div_cnt 0..CLK_DIV-1, incrementing every clk and wrapping to 0; pix_tick = (div_cnt==CLK_DIV-1); with CLK_DIV=1, pix_tick is constantly high outside reset.
REQ-013 SHALL advance col on each clk edge where pix_tick=1: 799 wraps to 0, otherwise col+1; col holds when pix_tick=0.
REQ-014 SHALL increment row only on the col 799->0 transition: 524 wraps to 0, otherwise row+1.
REQ-015 SHALL increment frame_cnt (mod 256, 255->0) only on the simultaneous transition (col,row) (799,524)->(0,0).
REQ-016 SHALL derive visible combinationally from the registered col/row, with zero latency relative to the col/row outputs.
REQ-017 SHALL drive hsync_n low for col in 656..751 inclusive (96 pixels), high otherwise.
REQ-018 SHALL drive vsync_n low for row in 490..491 inclusive (2 lines), high otherwise.
REQ-019 SHALL assert line_start = pix_tick and col==0, giving exactly one clk per line.
REQ-020 SHALL assert frame_start = pix_tick and col==0 and row==0, giving exactly one clk per frame; frame_start implies line_start.
REQ-021 SHALL keep every output a function of registered state only, with no combinational path from reset to any output other than through the registers.
REQ-022 SHALL keep col/row stable for exactly CLK_DIV clks per pixel, so the downstream background generator's col[9:2]/row[9:2] address is stable for 4*CLK_DIV clks.

Reset
REQ-023 SHALL, while reset=1 at a clk edge, load div_cnt=0, col=0, row=0, frame_cnt=0.
REQ-024 SHALL force pix_tick, line_start and frame_start to 0 while reset=1.
REQ-025 SHALL, on release, place the first pix_tick CLK_DIV-1 clks after the first non-reset edge, with frame_start asserted on that tick.
REQ-026 SHALL, on reset asserted mid-frame, abandon the frame at the next edge with no frame_cnt increment, and SHALL hold hsync_n=vsync_n=1 (consistent with col=row=0).

Structure
REQ-027 SHALL place the timing constants in shared package vga_pkg: H_VIS=640, H_FP=16, H_SYNC=96, H_BP=48, H_TOTAL=800, V_VIS=480, V_FP=10, V_SYNC=2, V_BP=33, V_TOTAL=525, and typedef coord_t (10-bit unsigned).
REQ-028 SHALL express sync windows as VIS+FP to VIS+FP+SYNC-1 using package constants, with no bare literals in the RTL.
REQ-029 SHALL implement the pixel divider as the single sub-module tick_divider (parameter CLK_DIV; ports clk, reset, tick); the col and row counters are inline.

Verification
REQ-030 SHALL cover reset release with CLK_DIV=2 -> pix_tick first high on clk 1, frame_start=1 on that clk, and col=1 at clk 2.
REQ-031 SHALL cover one full line -> line_start every 1600 clks, hsync_n low for exactly 192 clks beginning when col=656, and visible low from col=640.
REQ-032 SHALL cover one full frame -> frame_start period 840000 clks, vsync_n low for exactly 1600*2 clks at rows 490-491, and frame_cnt 0->1.
REQ-033 SHALL cover 256 frames, accelerated via forced counters -> frame_cnt wraps 255->0 at (799,524)->(0,0).
REQ-034 SHALL cover reset asserted at col=700, row=300 -> next clk col=row=0, strobes low, frame_cnt unchanged.
REQ-035 SHALL cover CLK_DIV=1 and CLK_DIV=4 -> line period 800 and 3200 clks respectively, with sync widths scaled identically.
